me_serial_rx: RTL and testbench
===============================

// Module: me_serial_rx
// PURPOSE
//  Receive-side deserializer for the ME chip's 1-bit serial20 result line; runs on the tester/FPGA side, same clock.
//  Frames each serial result into a RESULT_W-bit word, checks framing, buffers words in a small FIFO.
//  Presents words to downstream logic via valid/ready.
//  Reports framing errors, overflow and frame counts.
// PARAMETERS
//  RESULT_W    20  data bits per frame (result word width)
//  FIFO_DEPTH  4   output FIFO entries; power of two, >=2
//  CNT_W       16  width of frame/error counters
// PORTS
//  clk        in   1         single clock, rising edge
//  rst_n      in   1         asynchronous active-low reset
//  init       in   1         synchronous clear: FSM, FIFO, counters, sticky flags
//  serial_in  in   1         serial20 line from chip
//  out_data   out  RESULT_W  received word, FIFO head
//  out_valid  out  1         FIFO non-empty
//  out_ready  in   1         downstream accepts; pop when out_valid&out_ready
//  frame_err  out  1         one-cycle pulse on bad stop bit
//  overflow   out  1         sticky: a good word was dropped on full FIFO
//  frame_cnt  out  CNT_W     good frames received, wraps
//  err_cnt    out  CNT_W     framing errors, wraps
// BEHAVIOUR
//  Line protocol: one bit per clk; idle 0.
//  Frame = start bit 1, RESULT_W data bits MSB first, stop bit 0. Total RESULT_W+2 cycles.
//  Back-to-back frames are legal: the next start bit may follow the stop bit directly.
//  serial_in is registered once (s_q); the FSM acts on s_q only.
//  FSM states:
//   IDLE: s_q==1 -> DATA, bit_cnt=0.
//   DATA: shift s_q into shreg; when bit_cnt==RESULT_W-1 -> STOP.
//   STOP: s_q==0 -> push shreg, -> IDLE. s_q==1 -> frame_err pulse, err_cnt++, word discarded, -> IDLE.
//   A 1 seen as a bad stop bit is never taken as a start bit.
//  Latency: stop bit on serial_in at edge t -> word written at edge t+2 -> out_valid high after t+2.
//  Push accepted, FIFO not full: frame_cnt++.
//  Push, FIFO full, no pop that cycle: word dropped, overflow<=1, frame_cnt++.
//   overflow holds until init or rst_n.
//  Push and pop in the same cycle on a full FIFO: both succeed; occupancy unchanged.
//  Pop on empty FIFO: ignored. out_data is don't-care while out_valid=0.
//  frame_cnt and err_cnt wrap at 2^CNT_W-1 -> 0.
//  Reset (async) and init (sync) clear:
//   s_q=0, FSM=IDLE, FIFO empty, out_valid=0, out_data=0, frame_err=0, overflow=0, counters=0.
//  init has priority over all other events in its cycle.
//  A frame in progress when init/reset asserts is abandoned; reception resumes at the next start bit after release.
// STRUCTURE
//  Shared package me_pkg:
//   RESULT_W; field widths/offsets of the result word (MV x, MV y, SAD); FSM state encoding.
//  Sub-module me_sync_fifo:
//   Parameterised width/depth; push/pop/full/empty; simultaneous push+pop when full.
//   The rest (input flop, FSM, shift register, counters) is inline.
// TESTING
//  1. Frame 1,0xA5C3E,0 after idle -> out_valid 2 clk after stop bit, out_data=0xA5C3E, frame_cnt=1.
//  2. Three back-to-back frames (0x00001,0xFFFFF,0x80000), out_ready=1 -> three words in order, no frame_err.
//  3. Frame with stop bit 1 -> frame_err pulse 1 clk, err_cnt=1, no push.
//     Next valid frame -> received correctly.
//  4. out_ready=0, send 5 frames -> FIFO holds first 4, overflow=1, frame_cnt=5.
//     Drain -> words 1..4 only.
//  5. Full FIFO, pop coincides with 5th push -> no overflow; occupancy stays 4.
//  6. init asserted mid-frame (after 10 data bits) -> all cleared, tail bits ignored; next full frame received intact.

Source files
------------

// File: rtl/me_pkg.sv
// rtl/me_pkg.sv - shared types and constants for the ME serial result receiver
package me_pkg;

  localparam int ME_RESULT_W = 20;

  // Result word layout, MSB first on the wire: {mv_x, mv_y, sad}
  localparam int MV_X_W   = 5;
  localparam int MV_Y_W   = 5;
  localparam int SAD_W    = 10;
  localparam int SAD_LSB  = 0;
  localparam int MV_Y_LSB = SAD_W;
  localparam int MV_X_LSB = SAD_W + MV_Y_W;

  typedef struct packed {
    logic [MV_X_W-1:0] mv_x;
    logic [MV_Y_W-1:0] mv_y;
    logic [SAD_W-1:0]  sad;
  } me_result_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_STOP = 2'd2
  } rx_state_e;

  function automatic me_result_t me_unpack(input logic [ME_RESULT_W-1:0] w);
    return me_result_t'(w);
  endfunction

endpackage

// File: rtl/me_sync_fifo.sv
// rtl/me_sync_fifo.sv - single-clock FIFO with registered storage
// Accepts a push on a full FIFO when a pop happens in the same cycle.
module me_sync_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (init) begin
      for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Storage is cleared on reset so the head reads zero while empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/me_serial_rx.sv
// rtl/me_serial_rx.sv - serial20 result line deserializer with framing check and output FIFO
module me_serial_rx
  import me_pkg::*;
#(
  parameter int RESULT_W   = me_pkg::ME_RESULT_W,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                init,
  input  logic                serial_in,
  output logic [RESULT_W-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                frame_err,
  output logic                overflow,
  output logic [CNT_W-1:0]    frame_cnt,
  output logic [CNT_W-1:0]    err_cnt
);

  localparam int BC_W = $clog2(RESULT_W);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(RESULT_W - 1);

  logic                s_q, s_d;
  rx_state_e           state_q;
  logic [BC_W-1:0]     bit_cnt_q;
  logic [RESULT_W-1:0] shreg_q;
  logic                push_q;
  logic                frame_err_q;
  logic                overflow_q, overflow_d;
  logic [CNT_W-1:0]    frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
  logic                fifo_full, fifo_empty, pop;

  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;
  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;

  // shreg_q is stable until the next frame's first data bit, so it feeds the FIFO directly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else if (init) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (s_q) begin
            state_q   <= ST_DATA;
            bit_cnt_q <= '0;
          end
        end
        ST_DATA: begin
          shreg_q   <= {shreg_q[RESULT_W-2:0], s_q};
          bit_cnt_q <= bit_cnt_q + BC_W'(1);
          if (bit_cnt_q == LAST_BIT) state_q <= ST_STOP;
        end
        ST_STOP: begin
          if (s_q) frame_err_q <= 1'b1;
          else     push_q      <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    s_d         = serial_in;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    overflow_d  = overflow_q;
    if (init) begin
      s_d         = 1'b0;
      frame_cnt_d = '0;
      err_cnt_d   = '0;
      overflow_d  = 1'b0;
    end else begin
      // A good frame counts even when the FIFO has to drop it
      if (push_q) frame_cnt_d = frame_cnt_q + CNT_W'(1);
      if (state_q == ST_STOP && s_q) err_cnt_d = err_cnt_q + CNT_W'(1);
      if (push_q && fifo_full && !pop) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q         <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      s_q         <= s_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
      overflow_q  <= overflow_d;
    end
  end

  me_sync_fifo #(
    .WIDTH (RESULT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .init      (init),
    .push      (push_q),
    .push_data (shreg_q),
    .pop       (pop),
    .pop_data  (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_me_serial_rx.sv
// tb/tb_me_serial_rx.sv - directed self-checking bench for me_serial_rx
module tb_me_serial_rx;

  localparam int RW = 20;
  localparam int FD = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          init = 1'b0;
  logic          serial_in = 1'b0;
  logic          out_ready = 1'b0;
  logic [RW-1:0] out_data;
  logic          out_valid;
  logic          frame_err;
  logic          overflow;
  logic [CW-1:0] frame_cnt;
  logic [CW-1:0] err_cnt;

  int checks = 0;
  int failures = 0;
  int err_pulses = 0;
  logic [RW-1:0] rx_q[$];
  logic [RW-1:0] exp_q[$];

  always #5 clk = ~clk;

  me_serial_rx #(
    .RESULT_W   (RW),
    .FIFO_DEPTH (FD),
    .CNT_W      (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .init      (init),
    .serial_in (serial_in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err),
    .overflow  (overflow),
    .frame_cnt (frame_cnt),
    .err_cnt   (err_cnt)
  );

  always @(negedge clk) begin
    if (out_valid && out_ready && !init) rx_q.push_back(out_data);
    if (frame_err) err_pulses++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    serial_in = b;
    step();
  endtask

  task automatic send_frame(input logic [RW-1:0] w, input logic stop);
    send_bit(1'b1);
    for (int i = RW - 1; i >= 0; i--) send_bit(w[i]);
    send_bit(stop);
    serial_in = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    out_ready = 1'b1;
    while (out_valid && n < budget) begin
      step();
      n++;
    end
    check_eq("drain_empty", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;
  endtask

  task automatic check_rx(input string tag);
    check_eq($sformatf("%s_count", tag), rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check_eq($sformatf("%s_word%0d", tag, i), {12'd0, rx_q[i]}, {12'd0, exp_q[i]});
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    step();
    rst_n = 1'b1;
    step();
    check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_data", {12'd0, out_data}, 32'd0);
    check_eq("rst_ferr", {31'd0, frame_err}, 32'd0);
    check_eq("rst_ovf", {31'd0, overflow}, 32'd0);
    check_eq("rst_fcnt", {16'd0, frame_cnt}, 32'd0);
    check_eq("rst_ecnt", {16'd0, err_cnt}, 32'd0);
    step();
    step();

    // 1: single frame, latency of two edges after the stop bit
    send_frame(20'hA5C3E, 1'b0);
    step();
    check_eq("t1_valid_t1", {31'd0, out_valid}, 32'd0);
    step();
    check_eq("t1_valid_t2", {31'd0, out_valid}, 32'd1);
    check_eq("t1_data", {12'd0, out_data}, 32'h000A5C3E);
    check_eq("t1_fcnt", {16'd0, frame_cnt}, 32'd1);
    exp_q.push_back(20'hA5C3E);
    drain(8);
    check_rx("t1_rx");

    // 2: back-to-back frames with downstream always ready
    out_ready = 1'b1;
    err_pulses = 0;
    send_frame(20'h00001, 1'b0);
    send_frame(20'hFFFFF, 1'b0);
    send_frame(20'h80000, 1'b0);
    repeat (4) step();
    exp_q.push_back(20'h00001);
    exp_q.push_back(20'hFFFFF);
    exp_q.push_back(20'h80000);
    check_rx("t2_rx");
    check_eq("t2_no_ferr", err_pulses, 32'd0);
    check_eq("t2_fcnt", {16'd0, frame_cnt}, 32'd4);
    check_eq("t2_valid", {31'd0, out_valid}, 32'd0);

    // 3: bad stop bit, then a good frame
    send_frame(20'h12345, 1'b1);
    step();
    check_eq("t3_ferr_hi", {31'd0, frame_err}, 32'd1);
    check_eq("t3_ecnt", {16'd0, err_cnt}, 32'd1);
    step();
    check_eq("t3_ferr_lo", {31'd0, frame_err}, 32'd0);
    check_eq("t3_no_push", {31'd0, out_valid}, 32'd0);
    check_eq("t3_fcnt_hold", {16'd0, frame_cnt}, 32'd4);
    send_frame(20'h54321, 1'b0);
    repeat (4) step();
    exp_q.push_back(20'h54321);
    check_rx("t3_rx");
    check_eq("t3_fcnt", {16'd0, frame_cnt}, 32'd5);
    check_eq("t3_ecnt_hold", {16'd0, err_cnt}, 32'd1);
    check_eq("t3_pulses", err_pulses, 32'd1);

    // 4: five frames into a stalled FIFO
    out_ready = 1'b0;
    init = 1'b1;
    step();
    init = 1'b0;
    check_eq("t4_init_fcnt", {16'd0, frame_cnt}, 32'd0);
    check_eq("t4_init_ecnt", {16'd0, err_cnt}, 32'd0);
    check_eq("t4_init_valid", {31'd0, out_valid}, 32'd0);
    for (int k = 1; k <= 5; k++) send_frame(RW'(k * 32'h11111), 1'b0);
    repeat (3) step();
    check_eq("t4_ovf", {31'd0, overflow}, 32'd1);
    check_eq("t4_fcnt", {16'd0, frame_cnt}, 32'd5);
    check_eq("t4_head", {12'd0, out_data}, 32'h00011111);
    for (int k = 1; k <= 4; k++) exp_q.push_back(RW'(k * 32'h11111));
    drain(10);
    check_rx("t4_rx");
    check_eq("t4_ovf_sticky", {31'd0, overflow}, 32'd1);

    // 5: pop coincides with the push into a full FIFO
    init = 1'b1;
    step();
    init = 1'b0;
    check_eq("t5_init_ovf", {31'd0, overflow}, 32'd0);
    for (int k = 1; k <= 4; k++) send_frame(RW'(k * 32'h01010), 1'b0);
    repeat (3) step();
    check_eq("t5_ovf_pre", {31'd0, overflow}, 32'd0);
    check_eq("t5_fcnt_pre", {16'd0, frame_cnt}, 32'd4);
    send_frame(20'h05050, 1'b0);
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq("t5_ovf", {31'd0, overflow}, 32'd0);
    check_eq("t5_fcnt", {16'd0, frame_cnt}, 32'd5);
    check_eq("t5_valid", {31'd0, out_valid}, 32'd1);
    for (int k = 1; k <= 5; k++) exp_q.push_back(RW'(k * 32'h01010));
    drain(10);
    check_rx("t5_rx");

    // 6: init in the middle of a frame, held across its tail
    out_ready = 1'b1;
    err_pulses = 0;
    begin
      logic [RW-1:0] w;
      w = 20'hABCDE;
      send_bit(1'b1);
      for (int i = RW - 1; i >= 10; i--) send_bit(w[i]);
      init = 1'b1;
      for (int i = 9; i >= 0; i--) send_bit(w[i]);
      send_bit(1'b0);
    end
    check_eq("t6_init_fcnt", {16'd0, frame_cnt}, 32'd0);
    check_eq("t6_init_valid", {31'd0, out_valid}, 32'd0);
    init = 1'b0;
    send_bit(1'b0);
    send_bit(1'b0);
    send_frame(20'h13579, 1'b0);
    repeat (4) step();
    exp_q.push_back(20'h13579);
    check_rx("t6_rx");
    check_eq("t6_fcnt", {16'd0, frame_cnt}, 32'd1);
    check_eq("t6_ecnt", {16'd0, err_cnt}, 32'd0);
    check_eq("t6_pulses", err_pulses, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
